axis_frame_hdr_sequencer: RTL and testbench
===========================================

# axis_frame_hdr_sequencer

Sequences the two output streams of the frame length adjust FIFO: it accepts one header from the header FIFO, then forwards exactly the matching frame from the data FIFO. It never lets data run ahead of its header, and it optionally discards frames whose header reports truncation. It sits between the length adjust FIFO outputs and the downstream consumer. It also checks the delivered byte count against the header length and keeps frame and drop statistics.

## Interface
Parameters:
- DATA_WIDTH, 8: tdata width in bits.
- KEEP_ENABLE, (DATA_WIDTH>8): use tkeep. When 0, each beat counts as KEEP_WIDTH bytes.
- KEEP_WIDTH, ((DATA_WIDTH+7)/8): tkeep width.
- ID_ENABLE, 0 / ID_WIDTH, 8: tid pass-through.
- DEST_ENABLE, 0 / DEST_WIDTH, 8: tdest pass-through.
- USER_ENABLE, 1 / USER_WIDTH, 1: tuser pass-through.

Ports:
- clk  in  1: clock. All logic is on the rising edge.
- rst  in  1: synchronous, active-high reset.
- s_axis_hdr_valid/ready  in/out  1: input header handshake.
- s_axis_hdr_pad, s_axis_hdr_truncate  in  1: header flags.
- s_axis_hdr_length, s_axis_hdr_original_length  in  16: byte lengths.
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in/out  per parameters: input frame data.
- m_axis_hdr_valid/ready  out/in  1: output header handshake.
- m_axis_hdr_pad, m_axis_hdr_truncate  out  1: registered header flags.
- m_axis_hdr_length, m_axis_hdr_original_length  out  16: registered header lengths.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out/in  per parameters: output frame data.
- drop_truncated  in  1: when 1, frames whose header has truncate=1 are discarded. Sampled at header acceptance.
- status_frame_count  out  32: count of frames forwarded.
- status_drop_count  out  32: count of frames dropped.
- status_length_error  out  1: one-cycle pulse when a forwarded frame's byte count differs from its header length.

## Operation
The block is a four-state machine: IDLE, HDR, PASS, DROP.

- **IDLE**
  - s_axis_hdr_ready=1. s_axis_tready=0. m_axis_tvalid=0.
  - On header handshake, register all four header fields and clear the byte counter.
  - If drop_truncated and truncate are both 1, go to DROP. Otherwise go to HDR.
- **HDR**
  - m_axis_hdr_valid=1 with the registered fields. s_axis_hdr_ready=0. s_axis_tready=0.
  - On m_axis_hdr_ready, go to PASS.
- **PASS**
  - Combinational pass-through: m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, and all sideband signals pass directly.
  - On each output transfer, add the beat's bytes to the byte counter. The beat's bytes are popcount(tkeep), or KEEP_WIDTH when KEEP_ENABLE=0.
  - The byte counter is 17 bits and saturates at 0x1FFFF.
  - On the transfer with tlast=1:
    - increment status_frame_count;
    - compare the final count, including that beat, with the registered length; if they differ, pulse status_length_error the next cycle;
    - go to IDLE.
- **DROP**
  - s_axis_tready=1 and m_axis_tvalid=0. Input beats are discarded.
  - On the beat with tlast=1, increment status_drop_count and go to IDLE.

Counters:
- Both status counters are 32 bits and wrap from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - state=IDLE.
  - m_axis_hdr_valid=0. m_axis_tvalid=0. s_axis_tready=0. s_axis_hdr_ready=0 during the reset cycle, then 1.
  - Header registers are 0. Both counters are 0. status_length_error=0.
- Header latency: a header accepted in cycle N is presented on m_axis_hdr_valid in cycle N+1.
- Data latency: zero cycles in PASS. The earliest data transfer is in the cycle after the m_axis_hdr handshake.
- Back-to-back frames:
  - The tlast transfer in cycle N puts the block in IDLE at N+1.
  - The next header can be accepted at N+1. Its m_axis_hdr_valid is asserted at N+2.
- The output header fields hold stable while m_axis_hdr_valid=1 and m_axis_hdr_ready=0.
- Input data arriving before its header is stalled (s_axis_tready=0). It is never consumed early.
- status_length_error is asserted for exactly one cycle, at N+1 after the tlast transfer in cycle N.
- Reset mid-frame returns the block to IDLE immediately. It performs no flush. Any remaining beats of that frame are the upstream's responsibility; the upstream FIFOs are reset on the same rst.

## Test plan
1. Header length=4, pad=0, truncate=0, DATA_WIDTH=8; four beats with tlast on the fourth, no backpressure. Required:
   - m_axis_hdr_valid asserts one cycle after the header handshake;
   - four beats pass unchanged;
   - status_frame_count=1 and no status_length_error.
2. drop_truncated=1; header truncate=1, length=3; three input beats. Required:
   - no m_axis_hdr_valid and no m_axis_tvalid;
   - s_axis_tready=1 for all three beats;
   - status_drop_count=1 and status_frame_count=0.
3. Header length=5 but the frame ends after 3 bytes. Required: status_length_error pulses for exactly one cycle, and status_frame_count=1.
4. s_axis_tvalid is held high with data present while no header is valid for 10 cycles. Required: s_axis_tready=0 throughout; data is consumed only after the header is forwarded.
5. KEEP_ENABLE=1, DATA_WIDTH=32; header length=6; beats with tkeep=4'hF then 4'h3 (tlast). Required: byte count is 6, with no error.
6. Random m_axis_hdr_ready and m_axis_tready backpressure over 100 frames. Required:
   - header and data order is preserved;
   - status_frame_count=100;
   - header fields are stable while stalled;
   - asserting rst mid-frame returns all outputs to their reset values on the next cycle.

Source files
------------

// File: rtl/axis_frame_hdr_sequencer.sv
// axis_frame_hdr_sequencer: forwards one header then exactly its frame, optionally dropping truncated frames
module axis_frame_hdr_sequencer #(
   parameter int DATA_WIDTH  = 8,
   parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
   parameter bit ID_ENABLE   = 0,
   parameter int ID_WIDTH    = 8,
   parameter bit DEST_ENABLE = 0,
   parameter int DEST_WIDTH  = 8,
   parameter bit USER_ENABLE = 1,
   parameter int USER_WIDTH  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_axis_hdr_valid,
   output logic                  s_axis_hdr_ready,
   input  logic                  s_axis_hdr_pad,
   input  logic                  s_axis_hdr_truncate,
   input  logic [15:0]           s_axis_hdr_length,
   input  logic [15:0]           s_axis_hdr_original_length,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [ID_WIDTH-1:0]   s_axis_tid,
   input  logic [DEST_WIDTH-1:0] s_axis_tdest,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic                  m_axis_hdr_valid,
   input  logic                  m_axis_hdr_ready,
   output logic                  m_axis_hdr_pad,
   output logic                  m_axis_hdr_truncate,
   output logic [15:0]           m_axis_hdr_length,
   output logic [15:0]           m_axis_hdr_original_length,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [ID_WIDTH-1:0]   m_axis_tid,
   output logic [DEST_WIDTH-1:0] m_axis_tdest,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   input  logic                  drop_truncated,
   output logic [31:0]           status_frame_count,
   output logic [31:0]           status_drop_count,
   output logic                  status_length_error
);
   typedef enum logic [1:0] {IDLE, HDR, PASS, DROP} state_t;
   state_t state_q, state_d;
   logic pad_q, pad_d, trunc_q, trunc_d, err_q, err_d;
   logic [15:0] len_q, len_d, olen_q, olen_d;
   logic [16:0] cnt_q, cnt_d, beat_bytes, cnt_sum;
   logic [17:0] raw_sum;
   logic [31:0] frame_q, frame_d, drop_q, drop_d;
   assign beat_bytes = KEEP_ENABLE ? 17'($countones(s_axis_tkeep)) : 17'(KEEP_WIDTH);
   assign raw_sum = {1'b0, cnt_q} + {1'b0, beat_bytes};
   assign cnt_sum = raw_sum[17] ? '1 : raw_sum[16:0];
   assign m_axis_tdata = s_axis_tdata;
   assign m_axis_tkeep = KEEP_ENABLE ? s_axis_tkeep : '1;
   assign m_axis_tlast = s_axis_tlast;
   assign m_axis_tid = ID_ENABLE ? s_axis_tid : '0;
   assign m_axis_tdest = DEST_ENABLE ? s_axis_tdest : '0;
   assign m_axis_tuser = USER_ENABLE ? s_axis_tuser : '0;
   assign m_axis_hdr_pad = pad_q;
   assign m_axis_hdr_truncate = trunc_q;
   assign m_axis_hdr_length = len_q;
   assign m_axis_hdr_original_length = olen_q;
   assign status_frame_count = frame_q;
   assign status_drop_count = drop_q;
   assign status_length_error = err_q;
   always_comb begin
      state_d = state_q;
      pad_d = pad_q;
      trunc_d = trunc_q;
      len_d = len_q;
      olen_d = olen_q;
      cnt_d = cnt_q;
      frame_d = frame_q;
      drop_d = drop_q;
      err_d = 1'b0;
      s_axis_hdr_ready = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_hdr_valid = 1'b0;
      case (state_q)
         IDLE: begin
            s_axis_hdr_ready = !rst;
            if (s_axis_hdr_valid && !rst) begin
               pad_d = s_axis_hdr_pad;
               trunc_d = s_axis_hdr_truncate;
               len_d = s_axis_hdr_length;
               olen_d = s_axis_hdr_original_length;
               cnt_d = '0;
               state_d = (drop_truncated && s_axis_hdr_truncate) ? DROP : HDR;
            end
         end
         HDR: begin
            m_axis_hdr_valid = 1'b1;
            state_d = m_axis_hdr_ready ? PASS : HDR;
         end
         PASS: begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            if (s_axis_tvalid && m_axis_tready) begin
               cnt_d = cnt_sum;
               if (s_axis_tlast) begin
                  frame_d = frame_q + 32'd1;
                  err_d = cnt_sum != {1'b0, len_q};
                  state_d = IDLE;
               end
            end
         end
         DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               drop_d = drop_q + 32'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pad_q <= 1'b0;
         trunc_q <= 1'b0;
         len_q <= '0;
         olen_q <= '0;
         cnt_q <= '0;
         frame_q <= '0;
         drop_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pad_q <= pad_d;
         trunc_q <= trunc_d;
         len_q <= len_d;
         olen_q <= olen_d;
         cnt_q <= cnt_d;
         frame_q <= frame_d;
         drop_q <= drop_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_axis_frame_hdr_sequencer.sv
// tb_axis_frame_hdr_sequencer: directed frames with a header/beat scoreboard checked by a separate monitor
module tb_axis_frame_hdr_sequencer;
   typedef struct {logic pad; logic trunc; logic [15:0] len; logic [15:0] olen;} hdr_t;
   typedef struct {logic [31:0] data; logic [3:0] keep; logic last; logic [7:0] id; logic [7:0] dest; logic user; bit err;} beat_t;
   logic clk = 0, rst = 1;
   logic s_axis_hdr_valid = 0, s_axis_hdr_ready, s_axis_hdr_pad = 0, s_axis_hdr_truncate = 0;
   logic [15:0] s_axis_hdr_length = 0, s_axis_hdr_original_length = 0;
   logic [31:0] s_axis_tdata = 0, m_axis_tdata;
   logic [3:0] s_axis_tkeep = 0, m_axis_tkeep;
   logic s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0, m_axis_tlast;
   logic [7:0] s_axis_tid = 0, s_axis_tdest = 0, m_axis_tid, m_axis_tdest;
   logic [0:0] s_axis_tuser = 0, m_axis_tuser;
   logic m_axis_hdr_valid, m_axis_hdr_ready = 1, m_axis_hdr_pad, m_axis_hdr_truncate;
   logic [15:0] m_axis_hdr_length, m_axis_hdr_original_length;
   logic m_axis_tvalid, m_axis_tready = 1, drop_truncated = 0;
   logic [31:0] status_frame_count, status_drop_count;
   logic status_length_error;
   int total = 0, passed = 0, fid = 0;
   bit rand_bp = 0, err_pend = 0;
   hdr_t hq[$];
   beat_t dq[$];

   axis_frame_hdr_sequencer #(.DATA_WIDTH(32), .KEEP_ENABLE(1), .KEEP_WIDTH(4), .ID_ENABLE(1), .ID_WIDTH(8),
      .DEST_ENABLE(1), .DEST_WIDTH(8), .USER_ENABLE(1), .USER_WIDTH(1)) dut (
      .clk(clk), .rst(rst),
      .s_axis_hdr_valid(s_axis_hdr_valid), .s_axis_hdr_ready(s_axis_hdr_ready),
      .s_axis_hdr_pad(s_axis_hdr_pad), .s_axis_hdr_truncate(s_axis_hdr_truncate),
      .s_axis_hdr_length(s_axis_hdr_length), .s_axis_hdr_original_length(s_axis_hdr_original_length),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
      .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
      .m_axis_hdr_valid(m_axis_hdr_valid), .m_axis_hdr_ready(m_axis_hdr_ready),
      .m_axis_hdr_pad(m_axis_hdr_pad), .m_axis_hdr_truncate(m_axis_hdr_truncate),
      .m_axis_hdr_length(m_axis_hdr_length), .m_axis_hdr_original_length(m_axis_hdr_original_length),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
      .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
      .drop_truncated(drop_truncated), .status_frame_count(status_frame_count),
      .status_drop_count(status_drop_count), .status_length_error(status_length_error));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial forever begin
      @(posedge clk);
      #1;
      m_axis_hdr_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis_tready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: headers are compared every cycle they are valid, so a stalled header must also hold its fields.
   always @(negedge clk) begin
      bit nerr;
      nerr = 0;
      if (rst) err_pend = 0;
      else begin
         if (m_axis_hdr_valid) begin
            if (hq.size() == 0) check("hdr_unexpected", 1, 0);
            else begin
               check("hdr_fields", {m_axis_hdr_pad, m_axis_hdr_truncate, m_axis_hdr_length, m_axis_hdr_original_length},
                  {hq[0].pad, hq[0].trunc, hq[0].len, hq[0].olen});
               if (m_axis_hdr_ready) void'(hq.pop_front());
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (dq.size() == 0 || hq.size() != 0) check("beat_unexpected_or_early", 1, 0);
            else begin
               beat_t b;
               b = dq.pop_front();
               check("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser},
                  {b.data, b.keep, b.last, b.id, b.dest, b.user});
               nerr = m_axis_tlast && b.err;
            end
         end
         if (err_pend || status_length_error) check("length_error_pulse", status_length_error, err_pend);
         err_pend = nerr;
      end
   end

   task automatic send_frame(input bit pad, input bit trunc, input logic [15:0] len, input logic [15:0] olen,
                             input int nb, input logic [3:0] mid_keep, input logic [3:0] last_keep, input int hdr_delay);
      bit dropf, hacc;
      int bytes;
      dropf = drop_truncated && trunc;
      hacc = 0;
      bytes = (nb - 1) * $countones(mid_keep) + $countones(last_keep);
      fid++;
      if (!dropf) begin
         hq.push_back('{pad, trunc, len, olen});
         for (int b = 0; b < nb; b++)
            dq.push_back('{{8'(fid), 8'(b), 16'hA5C3 ^ 16'(b * 7)}, (b == nb - 1) ? last_keep : mid_keep,
               b == nb - 1, 8'(fid), ~8'(fid), 1'(b), (b == nb - 1) && (bytes != int'(len))});
      end
      fork
         begin
            bit ok;
            ok = 0;
            repeat (hdr_delay) begin
               @(negedge clk);
               check("tready_before_hdr", s_axis_tready, 0);
            end
            @(posedge clk);
            #1;
            s_axis_hdr_valid = 1;
            s_axis_hdr_pad = pad;
            s_axis_hdr_truncate = trunc;
            s_axis_hdr_length = len;
            s_axis_hdr_original_length = olen;
            for (int t = 0; t < 300 && !ok; t++) begin
               @(negedge clk);
               ok = s_axis_hdr_valid && s_axis_hdr_ready;
            end
            check("hdr_accepted", ok, 1);
            @(posedge clk);
            #1;
            s_axis_hdr_valid = 0;
            hacc = 1;
            @(negedge clk);
            check("hdr_latency", m_axis_hdr_valid, !dropf);
         end
         begin
            for (int b = 0; b < nb; b++) begin
               bit ok;
               ok = 0;
               @(posedge clk);
               #1;
               s_axis_tvalid = 1;
               s_axis_tdata = {8'(fid), 8'(b), 16'hA5C3 ^ 16'(b * 7)};
               s_axis_tkeep = (b == nb - 1) ? last_keep : mid_keep;
               s_axis_tlast = b == nb - 1;
               s_axis_tid = 8'(fid);
               s_axis_tdest = ~8'(fid);
               s_axis_tuser = 1'(b);
               for (int t = 0; t < 300 && !ok; t++) begin
                  @(negedge clk);
                  if (dropf && hacc) check("drop_tready", s_axis_tready, 1);
                  ok = s_axis_tready;
               end
               check("beat_accepted", ok, 1);
            end
            @(posedge clk);
            #1;
            s_axis_tvalid = 0;
            s_axis_tlast = 0;
         end
      join
   endtask

   task automatic check_counts(input int frames, input int drops);
      @(negedge clk);
      check("frame_count", status_frame_count, 64'(frames));
      check("drop_count", status_drop_count, 64'(drops));
   endtask

   initial begin
      logic [3:0] lk_tab [4];
      lk_tab = '{4'hF, 4'h7, 4'h3, 4'h1};
      @(negedge clk);
      check("hdr_ready_in_reset", s_axis_hdr_ready, 0);
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      check("reset_outputs", {s_axis_hdr_ready, m_axis_hdr_valid, m_axis_tvalid, s_axis_tready, status_length_error},
         {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      check("reset_hdr_regs", {m_axis_hdr_pad, m_axis_hdr_truncate, m_axis_hdr_length, m_axis_hdr_original_length}, 0);
      check_counts(0, 0);
      send_frame(0, 0, 16'd4, 16'd4, 4, 4'h1, 4'h1, 0);
      check_counts(1, 0);
      drop_truncated = 1;
      send_frame(0, 1, 16'd3, 16'd9, 3, 4'h1, 4'h1, 0);
      check_counts(1, 1);
      drop_truncated = 0;
      send_frame(1, 0, 16'd5, 16'd5, 3, 4'h1, 4'h1, 0);
      check_counts(2, 1);
      send_frame(0, 0, 16'd8, 16'd8, 2, 4'hF, 4'hF, 10);
      check_counts(3, 1);
      send_frame(0, 0, 16'd6, 16'd6, 2, 4'hF, 4'h3, 0);
      check_counts(4, 1);
      rand_bp = 1;
      for (int i = 0; i < 100; i++) begin
         int nb;
         nb = (i % 4) + 1;
         send_frame(i[0], i[1], 16'((nb - 1) * 4 + $countones(lk_tab[i % 4])), 16'(100 + i), nb, 4'hF, lk_tab[i % 4], i % 3);
      end
      rand_bp = 0;
      check_counts(104, 1);
      check("queues_drained", 64'(hq.size() + dq.size()), 0);
      // Reset in the middle of a forwarded frame.
      hq.push_back('{1'b1, 1'b0, 16'd8, 16'd8});
      dq.push_back('{32'hDEAD_BEEF, 4'hF, 1'b0, 8'h11, 8'h22, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      s_axis_hdr_valid = 1;
      s_axis_hdr_pad = 1;
      s_axis_hdr_truncate = 0;
      s_axis_hdr_length = 8;
      s_axis_hdr_original_length = 8;
      @(posedge clk);
      #1;
      s_axis_hdr_valid = 0;
      s_axis_tvalid = 1;
      s_axis_tdata = 32'hDEAD_BEEF;
      s_axis_tkeep = 4'hF;
      s_axis_tlast = 0;
      s_axis_tid = 8'h11;
      s_axis_tdest = 8'h22;
      s_axis_tuser = 1;
      begin
         bit ok;
         ok = 0;
         for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = s_axis_tready;
         end
         check("midframe_beat_accepted", ok, 1);
      end
      @(posedge clk);
      #1;
      rst = 1;
      s_axis_tvalid = 0;
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      check("midreset_outputs", {s_axis_hdr_ready, m_axis_hdr_valid, m_axis_tvalid, s_axis_tready, status_length_error},
         {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      check("midreset_hdr_regs", {m_axis_hdr_pad, m_axis_hdr_truncate, m_axis_hdr_length, m_axis_hdr_original_length}, 0);
      check("midreset_counts", {status_frame_count, status_drop_count}, 0);
      check("midreset_queues", 64'(hq.size() + dq.size()), 0);
      send_frame(0, 0, 16'd4, 16'd4, 1, 4'hF, 4'hF, 0);
      check_counts(1, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
